// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
// The address check is kept here so other blocks can reuse it.
package dmem_arbiter_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 64;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Word accesses must be 4-byte aligned and start no later than the last word.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00) || (addr > ADDR_W'(MEM_BYTES - 4));
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the memory-side bus.
// "slave" is the arbiter's view; "master" is the requester/memory side.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_err;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_rdata, p1_err,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata,
    output busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_rdata, p1_err,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the loser of the last conflict wins the next one.
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_grant,
  output logic       o_valid
);

  logic r_last;

  // Starting at PORT_DBG lets the CPU port win the first conflict after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= PORT_DBG;
    end else if (i_update && o_valid) begin
      r_last <= o_grant;
    end
  end

  always_comb begin
    o_valid = |i_req;
    if (&i_req) begin
      o_grant = ~r_last;
    end else begin
      o_grant = i_req[1] & ~i_req[0];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the 64-byte data memory: IDLE -> ACCESS -> RESP,
// one strobe cycle per access, errored accesses never reach the memory.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  dmem_arbiter_if.slave bus
);

  state_t            r_state;
  state_t            w_next;
  logic              w_gnt;
  logic              w_gnt_valid;
  logic              w_grant_now;
  logic              w_err;

  logic              r_port;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;
  logic              r_p0_err;
  logic              r_p1_err;

  assign w_grant_now = (r_state == IDLE) && w_gnt_valid;
  assign w_err       = addr_err(r_addr);

  rr_arbiter2 u_rr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    ({bus.p1_req, bus.p0_req}),
    .i_update (w_grant_now),
    .o_grant  (w_gnt),
    .o_valid  (w_gnt_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus.p0_ack    = 1'b0;
    bus.p1_ack    = 1'b0;
    if (r_state == ACCESS && !w_err) begin
      bus.mem_addr  = r_addr;
      bus.mem_wdata = r_wdata;
      bus.mem_write = r_we;
      bus.mem_read  = ~r_we;
    end
    if (r_state == RESP) begin
      bus.p0_ack = (r_port == PORT_CPU);
      bus.p1_ack = (r_port == PORT_DBG);
    end
  end

  // Per-port result registers update at the end of ACCESS so they are valid with ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_port     <= PORT_CPU;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
      r_p0_err   <= 1'b0;
      r_p1_err   <= 1'b0;
    end else begin
      if (w_grant_now) begin
        r_port  <= w_gnt;
        r_we    <= w_gnt ? bus.p1_we    : bus.p0_we;
        r_addr  <= w_gnt ? bus.p1_addr  : bus.p0_addr;
        r_wdata <= w_gnt ? bus.p1_wdata : bus.p0_wdata;
      end
      if (r_state == ACCESS) begin
        if (r_port == PORT_CPU) begin
          r_p0_err <= w_err;
          if (!w_err && !r_we) r_p0_rdata <= bus.mem_rdata;
        end else begin
          r_p1_err <= w_err;
          if (!w_err && !r_we) r_p1_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.p0_rdata = r_p0_rdata;
  assign bus.p1_rdata = r_p1_rdata;
  assign bus.p0_err   = r_p0_err;
  assign bus.p1_err   = r_p1_err;
  assign bus.busy     = (r_state != IDLE);

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, byte-addressed 64-byte data memory between two requesters.
  - Port 0: CPU load/store stage.
  - Port 1: debug/DMA loader.
- Uses round-robin arbitration and a req/ack handshake.
- Drives the memory's read/write strobes, address and write data for exactly one cycle per access.
- Captures read data and flags misaligned or out-of-range word accesses before they reach the memory.

Parameters:
- DATA_W, 32, word width of requester and memory data buses.
- ADDR_W, 32, byte address width.
- MEM_BYTES, 64, memory size in bytes; the last legal word address is MEM_BYTES-4.

Ports:
- Clk  in  1  system clock, all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request, level, held until p0_ack.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  port 0 one-cycle completion pulse.
- p0_rdata  out  DATA_W  port 0 read data, valid with p0_ack.
- p0_err  out  1  port 0 access rejected, valid with p0_ack.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata, p1_err: same as port 0, for port 1.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read enable.
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (Rst sampled high at a rising edge):
  - state = IDLE; last_grant = 1, so port 0 wins the first conflict.
  - All outputs 0.
  - Any in-flight access is aborted with no ack.
  - A write strobe already high in that cycle still commits, because the memory samples the same edge.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Single request: grant that port.
  - Both requesting: grant the port != last_grant.
  - On grant: latch grant, we, addr and wdata into internal registers; update last_grant; go to ACCESS.
- ACCESS (exactly one cycle):
  - Error check: err_c = (addr[1:0] != 0) or (addr > MEM_BYTES-4).
  - If !err_c: mem_addr/mem_wdata come from the latched registers; mem_write = we; mem_read = !we.
  - If err_c: no strobe is asserted.
  - On read with no error: capture mem_rdata into the granted port's rdata register at the closing edge.
  - Go to RESP.
- RESP (one cycle):
  - Assert the granted port's ack.
  - err = err_c, registered.
  - The other port's ack stays 0.
  - rdata for writes and errored accesses: previous value held, not updated.
  - Go to IDLE.
- Strobes: mem_addr/mem_wdata are 0 outside ACCESS; mem_read and mem_write are never high together.
- Requester rules:
  - Inputs must be stable from req rise until ack.
  - Deassert req in the cycle after ack; if req is still high, it is taken as a new request.
  - A req dropped before ack is undefined; the block still completes the latched access.
- Timing:
  - Latency: req sampled at edge N -> strobe during cycle N+1 -> ack during cycle N+2.
  - Throughput: one access per 3 cycles.
  - Per-port rdata/err hold until that port's next RESP.
- Fairness: under continuous dual requests, grants strictly alternate; neither port waits more than one access.
- Width: the address comparison is unsigned over the full ADDR_W; upper bits set means out of range.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Port-index constants PORT_CPU=0, PORT_DBG=1.
  - Error-check function (alignment/range) so the CPU hazard logic can reuse it.
- One natural sub-module, rr_arbiter2: 2-way round-robin grant with last_grant state, update enable, grant valid.
- FSM and datapath registers stay in dmem_arbiter.

Test Plan:
- Single read: after reset, p0 read addr 0x08, memory holds 0xDEADBEEF there -> mem_read high in cycle 1 only, p0_ack in cycle 2, p0_rdata=0xDEADBEEF, p0_err=0, p1_ack=0.
- Write then read: p1 write 0x12345678 to 0x3C, then p1 read 0x3C -> mem_write exactly one cycle, readback 0x12345678, each access 3 cycles, busy high during ACCESS/RESP.
- Simultaneous requests: p0 and p1 both held high for 4 accesses from reset -> grant order p0, p1, p0, p1; acks one-hot, spaced 3 cycles apart.
- Errors: p0 read 0x06 (misaligned) and p0 read 0x40 (out of range) -> no mem_read/mem_write, p0_ack with p0_err=1, p0_rdata unchanged; p0 write 0x3C -> err=0.
- Reset mid-operation: Rst high during ACCESS of a p1 read -> no p1_ack, outputs 0 next cycle, state IDLE; subsequent p0 and p1 conflict grants p0.
- Back-to-back: p0 keeps req high after ack -> second access starts in the following IDLE cycle, acks 3 cycles apart.
